// File: rtl/sram_pkg.sv
// Shared defaults and FSM state encoding for the SRAM bank and its storage array.
package sram_pkg;

  localparam int SRAM_DATA_W   = 32;
  localparam int SRAM_ADDR_W   = 14;
  localparam int SRAM_DEPTH    = 16384;
  localparam int SRAM_READ_LAT = 1;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } bank_state_e;

  // Index width for a DEPTH-entry array; never below one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port-style storage: one byte-enabled write port and one registered read port.
module sram_array import sram_pkg::*; #(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int IDX_W  = idx_width(SRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wbe,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset; clearing is the bank's sweep job.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_bank.sv
// SRAM bank: init sweep FSM, address range check and fixed-latency response pipeline
// around a byte-enabled storage array.
module sram_bank import sram_pkg::*; #(
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DEPTH     = SRAM_DEPTH,
  parameter int READ_LAT  = SRAM_READ_LAT,
  parameter int INIT_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("sram_bank: DATA_W must be a positive multiple of 8");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("sram_bank: DEPTH must be in 1..2**ADDR_W");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("sram_bank: READ_LAT must be 1 or 2");
  end

  localparam int               IDX_W    = idx_width(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  bank_state_e           r_state, w_state_d;
  logic [IDX_W-1:0]      r_cnt, w_cnt_d;
  logic                  w_run, w_accept, w_in_range;
  logic [IDX_W-1:0]      w_idx;

  logic                  w_mem_we, w_mem_re;
  logic [IDX_W-1:0]      w_mem_waddr;
  logic [DATA_W-1:0]     w_mem_wdata, w_mem_rdata;
  logic [DATA_W/8-1:0]   w_mem_wbe;

  logic                  r_v1, r_rd1, r_err1;
  logic [DATA_W-1:0]     w_rdata1;

  assign w_run      = (r_state == StRun);
  assign req_ready  = w_run;
  assign init_done  = w_run;
  assign w_accept   = req_valid & w_run;
  assign w_in_range = ({1'b0, req_addr} < DEPTH_L);
  assign w_idx      = req_addr[IDX_W-1:0];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (r_state == StInit) begin
      if (INIT_ZERO != 0) begin
        if (r_cnt == LAST_IDX) begin
          w_state_d = StRun;
        end else begin
          w_cnt_d = r_cnt + IDX_W'(1);
        end
      end else begin
        w_state_d = StRun;
      end
    end
  end

  // The sweep owns the write port during INIT; requests cannot be accepted then.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = w_idx;
    w_mem_wdata = req_wdata;
    w_mem_wbe   = req_be;
    if (r_state == StInit) begin
      w_mem_we    = (INIT_ZERO != 0);
      w_mem_waddr = r_cnt;
      w_mem_wdata = '0;
      w_mem_wbe   = '1;
    end else begin
      w_mem_we = w_accept & req_we & w_in_range;
    end
  end

  assign w_mem_re = w_accept & ~req_we & w_in_range;

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_wbe   (w_mem_wbe),
    .i_re    (w_mem_re),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StInit;
      r_cnt   <= '0;
      r_v1    <= 1'b0;
      r_rd1   <= 1'b0;
      r_err1  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_v1    <= w_accept;
      r_rd1   <= w_mem_re;
      r_err1  <= w_accept & ~w_in_range;
    end
  end

  // Array output is only meaningful for in-range reads; everything else returns zero.
  assign w_rdata1 = (r_v1 & r_rd1) ? w_mem_rdata : '0;

  if (READ_LAT == 2) begin : g_lat2
    logic              r_v2, r_err2;
    logic [DATA_W-1:0] r_rdata2;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v2     <= 1'b0;
        r_err2   <= 1'b0;
        r_rdata2 <= '0;
      end else begin
        r_v2     <= r_v1;
        r_err2   <= r_err1;
        r_rdata2 <= w_rdata1;
      end
    end

    assign rsp_valid = r_v2;
    assign rsp_err   = r_err2;
    assign rsp_rdata = r_rdata2;
  end else begin : g_lat1
    assign rsp_valid = r_v1;
    assign rsp_err   = r_err1;
    assign rsp_rdata = w_rdata1;
  end

endmodule
